// File: rtl/bus_slave_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_slave_responder
// Description : Slave end of the master/slave bus. Accepts single-beat
//               read/write requests on a valid/ready request channel, backs
//               them with a small register file, and returns one response per
//               request on a valid/ready response channel after a fixed
//               number of wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_slave_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int DEPTH       = 12,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      c_WAIT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_cnt;
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_err;
    logic [DATA_W-1:0]  r_regs [0:DEPTH-1];

    logic               w_accept;
    logic               w_enter_resp;
    logic               w_in_range;
    logic               w_commit;

    // The WAIT state always spends one cycle decoding the latched address,
    // followed by WAIT_STATES programmable cycles; the counter is loaded with
    // WAIT_STATES and the response is produced once it has run down to zero.
    assign w_accept     = (r_state == S_IDLE) && req_valid;
    assign w_enter_resp = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_in_range   = ({1'b0, r_addr} < c_DEPTH);
    assign w_commit     = w_enter_resp && w_in_range && r_write;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (req_valid)            w_next_state = S_WAIT;
            S_WAIT: if (r_cnt == 4'd0)        w_next_state = S_RESP;
            S_RESP: if (resp_ready)           w_next_state = S_IDLE;
            default:                          w_next_state = S_IDLE;
        endcase
    end

    // Request capture and wait-state counter
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= c_WAIT;
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // Register file; writes commit on the edge that enters RESP
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[r_addr] <= r_wdata;
        end
    end

    // Response data/error, loaded on RESP entry and held through any stall
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            if (w_in_range) begin
                r_rdata <= r_write ? '0 : r_regs[r_addr];
                r_err   <= 1'b0;
            end else begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    // Outputs are pure state decode or registered values
    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_slave_responder
// Description : Scoreboard bench for bus_slave_responder. A driver issues
//               directed requests and queues expected responses; a monitor
//               pops and compares whenever a response is presented. A second
//               instance with WAIT_STATES=0 covers back-to-back timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_slave_responder;

    localparam int c_W = 2;

    logic        Clk;
    logic        Reset_n;
    logic        req_valid, req_write, resp_ready;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [15:0] resp_rdata;

    logic        req_valid0, req_write0, resp_ready0;
    logic [3:0]  req_addr0;
    logic [15:0] req_wdata0;
    logic        req_ready0, resp_valid0, resp_err0, busy0;
    logic [15:0] resp_rdata0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit seen     = 0;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          acc;
    } exp_t;
    exp_t q[$];

    logic [15:0] mem [0:11];

    bus_slave_responder #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .WAIT_STATES(c_W)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    bus_slave_responder #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .WAIT_STATES(0)) u_dut0 (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0), .busy(busy0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    // Issue one request; optionally queue its expected response
    task automatic do_req(input logic wr, input logic [3:0] addr, input logic [15:0] wd,
                          input logic [15:0] er, input logic ee, input bit push);
        int n = 0;
        @(negedge Clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge Clk);
        #1;
        if (push) q.push_back('{er, ee, cyc});
        @(negedge Clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: compare every presented response against the queue head
    always @(negedge Clk) begin
        #2;
        if (!Reset_n) begin
            seen = 0;
        end else if (resp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
            end else begin
                if (!seen) begin
                    chk("resp_latency", cyc - q[0].acc, c_W + 1);
                    seen = 1;
                end
                chk("resp_rdata", {16'd0, resp_rdata}, {16'd0, q[0].rdata});
                chk("resp_err", {31'd0, resp_err}, {31'd0, q[0].err});
                chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
                if (resp_ready) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Reset_n   = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd5; req_wdata = 16'hDEAD;
        resp_ready = 1'b1;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = 4'd0; req_wdata0 = 16'd0;
        resp_ready0 = 1'b1;
        for (int a = 0; a < 12; a++) mem[a] = 16'h0000;

        // Reset held with a request pending: no accept, idle outputs
        repeat (3) begin
            @(negedge Clk);
            chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
            chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_rdata", {16'd0, resp_rdata}, 32'd0);
            chk("rst_err", {31'd0, resp_err}, 32'd0);
        end
        Reset_n   = 1'b1;
        req_valid = 1'b0;
        @(negedge Clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Basic read of reset contents, write/read round trip
        do_req(1'b0, 4'd5, 16'h0000, 16'h0000, 1'b0, 1);
        wait_idle();
        do_req(1'b1, 4'd3, 16'hBEEF, 16'h0000, 1'b0, 1); mem[3] = 16'hBEEF;
        wait_idle();
        do_req(1'b0, 4'd3, 16'h0000, 16'hBEEF, 1'b0, 1);
        wait_idle();

        // Address boundaries: last valid register, first invalid, top of space
        do_req(1'b1, 4'd11, 16'h5A5A, 16'h0000, 1'b0, 1); mem[11] = 16'h5A5A;
        do_req(1'b1, 4'd13, 16'h1234, 16'h0000, 1'b1, 1);
        do_req(1'b0, 4'd13, 16'h0000, 16'h0000, 1'b1, 1);
        do_req(1'b1, 4'd12, 16'h7777, 16'h0000, 1'b1, 1);
        do_req(1'b0, 4'd15, 16'h0000, 16'h0000, 1'b1, 1);
        for (int a = 0; a < 12; a++) begin
            do_req(1'b0, 4'(a), 16'h0000, mem[a], 1'b0, 1);
        end
        wait_idle();

        // Backpressure: stall the read response for 10 cycles
        resp_ready = 1'b0;
        do_req(1'b0, 4'd3, 16'h0000, 16'hBEEF, 1'b0, 1);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("stall_reached_resp", {31'd0, resp_valid}, 32'd1);
        repeat (10) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd3; req_wdata = 16'hFFFF;
            @(negedge Clk);
        end
        chk("stall_still_valid", {31'd0, resp_valid}, 32'd1);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        wait_idle();
        chk("stall_back_idle", {31'd0, req_ready}, 32'd1);
        do_req(1'b0, 4'd3, 16'h0000, 16'hBEEF, 1'b0, 1);
        wait_idle();

        // WAIT_STATES=0 instance: continuous request, accepts at k and k+3
        @(negedge Clk);
        req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 4'd1; req_wdata0 = 16'h1111;
        chk("w0_ready_k", {31'd0, req_ready0}, 32'd1);
        @(negedge Clk);
        chk("w0_busy_k", {31'd0, busy0}, 32'd1);
        chk("w0_novalid_k", {31'd0, resp_valid0}, 32'd0);
        @(negedge Clk);
        chk("w0_valid_k1", {31'd0, resp_valid0}, 32'd1);
        chk("w0_wr_rdata", {16'd0, resp_rdata0}, 32'd0);
        chk("w0_wr_err", {31'd0, resp_err0}, 32'd0);
        req_write0 = 1'b0; req_wdata0 = 16'h0000;
        @(negedge Clk);
        chk("w0_ready_k2", {31'd0, req_ready0}, 32'd1);
        chk("w0_novalid_k2", {31'd0, resp_valid0}, 32'd0);
        @(negedge Clk);
        chk("w0_busy_k3", {31'd0, busy0}, 32'd1);
        chk("w0_novalid_k3", {31'd0, resp_valid0}, 32'd0);
        @(negedge Clk);
        chk("w0_valid_k4", {31'd0, resp_valid0}, 32'd1);
        chk("w0_rd_rdata", {16'd0, resp_rdata0}, 32'h1111);
        chk("w0_rd_err", {31'd0, resp_err0}, 32'd0);
        req_valid0 = 1'b0;
        @(negedge Clk);
        chk("w0_idle", {31'd0, busy0}, 32'd0);

        // Reset during WAIT of a write: discarded, no response, regs cleared
        do_req(1'b1, 4'd2, 16'hAAAA, 16'h0000, 1'b0, 0);
        chk("midrst_in_wait", {30'd0, busy, resp_valid}, 32'd2);
        #1 Reset_n = 1'b0;
        #1;
        chk("midrst_async_busy", {31'd0, busy}, 32'd0);
        chk("midrst_async_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        for (int a = 0; a < 12; a++) mem[a] = 16'h0000;
        repeat (6) begin
            @(negedge Clk);
            chk("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        do_req(1'b0, 4'd2, 16'h0000, mem[2], 1'b0, 1);
        do_req(1'b0, 4'd3, 16'h0000, mem[3], 1'b0, 1);
        wait_idle();
        chk("queue_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
